fu_mem_pipe: RTL and testbench

Parametrised memory functional unit for the out-of-order core. It is the successor of the single-shot load/store FU.
- Accepts one load/store per cycle in pipelined mode, or one in flight in blocking mode.
- Computes rs1+imm, accesses an internal byte-lane RAM and extends load data.
- Returns result, tag and fault status after a fixed latency.
- Sits between the issue stage (EN/ready) and the writeback/CDB arbiter (finish/tag_out).

---
 rtl/fu_mem_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/fu_mem_pipe.sv | 178 +++++++++++++++++
 tb/tb_fu_mem_pipe.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fu_mem_pkg.sv
// Shared constants and types for the memory functional unit: RISC-V funct3 encodings,
// fault codes and the per-op bookkeeping record carried down the delay pipe.
package fu_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_ILLEGAL  = 2'b10
    } fault_e;

    typedef struct packed {
        logic       is_store;
        fault_e     fault;
        logic [1:0] lane;
        logic [2:0] bhw;
    } ld_info_t;

    function automatic bit latency_ok(input int lat);
        return (lat >= 2) && (lat <= 8);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory FU: store byte enables and data replication,
// fault decode for the op in stage 1, and load lane extraction with sign/zero extension.
module mem_lane_align
    import fu_mem_pkg::*;
(
    input  logic        op_mem_w_i,
    input  logic [2:0]  op_bhw_i,
    input  logic [1:0]  op_addr_i,
    input  logic [31:0] op_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output fault_e      op_fault_o,
    input  ld_info_t    ld_info_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic illegal;
    logic misalign;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        illegal  = (op_bhw_i == 3'b011) || (op_bhw_i == 3'b110) || (op_bhw_i == 3'b111) ||
                   (op_mem_w_i && ((op_bhw_i == F3_BU) || (op_bhw_i == F3_HU)));
        misalign = ((op_bhw_i[1:0] == 2'b01) && op_addr_i[0]) ||
                   ((op_bhw_i == F3_W) && (op_addr_i != 2'b00));
        if (illegal) begin
            op_fault_o = FLT_ILLEGAL;
        end else if (misalign) begin
            op_fault_o = FLT_MISALIGN;
        end else begin
            op_fault_o = FLT_NONE;
        end
    end

    // Replicating the low bytes across the word lets the byte enables pick the lane.
    always_comb begin
        case (op_bhw_i[1:0])
            2'b00: begin
                st_be_o    = 4'b0001 << op_addr_i;
                st_wdata_o = {4{op_wdata_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = op_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{op_wdata_i[15:0]}};
            end
            default: begin
                st_be_o    = 4'b1111;
                st_wdata_o = op_wdata_i;
            end
        endcase
    end

    always_comb begin
        byte_v = ld_word_i[{ld_info_i.lane, 3'b000} +: 8];
        half_v = ld_info_i.lane[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_info_i.bhw)
            F3_B:    ld_data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   ld_data_o = {24'h0, byte_v};
            F3_H:    ld_data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   ld_data_o = {16'h0, half_v};
            F3_W:    ld_data_o = ld_word_i;
            default: ld_data_o = 32'h0;
        endcase
        if (ld_info_i.is_store || (ld_info_i.fault != FLT_NONE)) begin
            ld_data_o = 32'h0;
        end
    end

endmodule

// File: rtl/fu_mem_pipe.sv
// Memory functional unit: rs1+imm address, byte-lane RAM access in stage 1, then a
// fixed-length delay pipe to a registered result with tag and fault, LATENCY after accept.
module fu_mem_pipe
    import fu_mem_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 12,
    parameter int LATENCY   = 3,
    parameter int PIPELINED = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    output logic             ready,
    input  logic             mem_w,
    input  logic [2:0]       bhw,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic [TAG_W-1:0] tag_in,
    output logic             finish,
    output logic [XLEN-1:0]  mem_data,
    output logic [TAG_W-1:0] tag_out,
    output logic [1:0]       fault
);

    localparam int DEPTH = LATENCY - 1;
    localparam int TAIL  = LATENCY - 2;
    localparam int WORDS = 2 ** (ADDR_W - 2);

    if (!latency_ok(LATENCY) || (XLEN != 32)) begin : g_param_check
        $error("fu_mem_pipe: LATENCY must be 2..8 and XLEN must be 32");
    end

    logic             accept;
    logic             s1_valid_q;
    logic             s1_mem_w_q;
    logic [2:0]       s1_bhw_q;
    logic [XLEN-1:0]  s1_rs1_q;
    logic [XLEN-1:0]  s1_rs2_q;
    logic [XLEN-1:0]  s1_imm_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [XLEN-1:0]  addr;
    logic [ADDR_W-3:0] widx;
    logic             unused_addr_hi;

    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    fault_e           s1_fault;
    logic             ram_we;
    logic [31:0]      ld_data;

    logic [31:0]      ram [WORDS];
    logic [DEPTH-1:0] pv_q;
    logic [TAG_W-1:0] ptag_q  [DEPTH];
    ld_info_t         pinfo_q [DEPTH];
    logic [31:0]      pdata_q [DEPTH];

    logic             finish_q;
    logic [XLEN-1:0]  mem_data_q;
    logic [TAG_W-1:0] tag_out_q;
    fault_e           fault_q;
    logic             busy_q;
    logic             busy_d;

    // In blocking mode ready rises while the op sits in the last delay stage, so the
    // next accept coincides with the edge that registers the previous result.
    assign ready  = (PIPELINED != 0) ? 1'b1 : (~busy_q | pv_q[TAIL]);
    assign accept = EN & ready;

    assign addr           = s1_rs1_q + s1_imm_q;
    assign widx           = addr[ADDR_W-1:2];
    assign unused_addr_hi = ^addr[XLEN-1:ADDR_W];
    assign ram_we         = s1_valid_q && s1_mem_w_q && (s1_fault == FLT_NONE);

    mem_lane_align u_align (
        .op_mem_w_i (s1_mem_w_q),
        .op_bhw_i   (s1_bhw_q),
        .op_addr_i  (addr[1:0]),
        .op_wdata_i (s1_rs2_q),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .op_fault_o (s1_fault),
        .ld_info_i  (pinfo_q[TAIL]),
        .ld_word_i  (pdata_q[TAIL]),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mem_w_q <= 1'b0;
            s1_bhw_q   <= 3'b000;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_imm_q   <= '0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_mem_w_q <= mem_w;
                s1_bhw_q   <= bhw;
                s1_rs1_q   <= rs1_data;
                s1_rs2_q   <= rs2_data;
                s1_imm_q   <= imm;
                s1_tag_q   <= tag_in;
            end
        end
    end

    // RAM and the load-data delay line carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && st_be[b]) begin
                ram[widx][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
        if (s1_valid_q && !s1_mem_w_q) begin
            pdata_q[0] <= ram[widx];
        end
        for (int k = 1; k < DEPTH; k++) begin
            pdata_q[k] <= pdata_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ptag_q[k]  <= '0;
                pinfo_q[k] <= '0;
            end
        end else begin
            pv_q[0]    <= s1_valid_q;
            ptag_q[0]  <= s1_tag_q;
            pinfo_q[0] <= '{is_store: s1_mem_w_q, fault: s1_fault, lane: addr[1:0], bhw: s1_bhw_q};
            for (int k = 1; k < DEPTH; k++) begin
                pv_q[k]    <= pv_q[k-1];
                ptag_q[k]  <= ptag_q[k-1];
                pinfo_q[k] <= pinfo_q[k-1];
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d = 1'b1;
        end else if (pv_q[TAIL]) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            mem_data_q <= '0;
            tag_out_q  <= '0;
            fault_q    <= FLT_NONE;
        end else begin
            busy_q   <= busy_d;
            finish_q <= pv_q[TAIL];
            if (pv_q[TAIL]) begin
                mem_data_q <= ld_data;
                tag_out_q  <= ptag_q[TAIL];
                fault_q    <= pinfo_q[TAIL].fault;
            end
        end
    end

    assign finish   = finish_q;
    assign mem_data = mem_data_q;
    assign tag_out  = tag_out_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_fu_mem_pipe.sv
// Directed bench: a pipelined instance (LATENCY 3) checked through an in-order expectation
// queue, and a blocking instance (LATENCY 4) checked cycle by cycle with EN held high.
module tb_fu_mem_pipe;
    import fu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    logic        p_en = 0, p_ready, p_mem_w = 0, p_finish;
    logic [2:0]  p_bhw = 0;
    logic [31:0] p_rs1 = 0, p_rs2 = 0, p_imm = 0, p_data;
    logic [3:0]  p_tag = 0, p_tag_out;
    logic [1:0]  p_fault;

    logic        b_en = 0, b_ready, b_mem_w = 0, b_finish;
    logic [2:0]  b_bhw = 0;
    logic [31:0] b_rs1 = 0, b_rs2 = 0, b_imm = 0, b_data;
    logic [3:0]  b_tag = 0, b_tag_out;
    logic [1:0]  b_fault;

    fu_mem_pipe #(.LATENCY(3), .PIPELINED(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .EN(p_en), .ready(p_ready), .mem_w(p_mem_w), .bhw(p_bhw),
        .rs1_data(p_rs1), .rs2_data(p_rs2), .imm(p_imm), .tag_in(p_tag),
        .finish(p_finish), .mem_data(p_data), .tag_out(p_tag_out), .fault(p_fault)
    );

    fu_mem_pipe #(.LATENCY(4), .PIPELINED(0)) u_blk (
        .clk(clk), .rst_n(rst_n), .EN(b_en), .ready(b_ready), .mem_w(b_mem_w), .bhw(b_bhw),
        .rs1_data(b_rs1), .rs2_data(b_rs2), .imm(b_imm), .tag_in(b_tag),
        .finish(b_finish), .mem_data(b_data), .tag_out(b_tag_out), .fault(b_fault)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [1:0]  fault;
        int          due;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (p_finish) begin
            $display("txn tag=%0d data=%h fault=%0d cyc=%0d", p_tag_out, p_data, p_fault, cyc);
            if (expq.size() == 0) begin
                check("spurious_finish", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                check("tag", {28'h0, p_tag_out}, {28'h0, mon_e.tag});
                check("data", p_data, mon_e.data);
                check("fault", {30'h0, p_fault}, {30'h0, mon_e.fault});
                check("latency", cyc, mon_e.due);
            end
        end else if (expq.size() != 0 && cyc > expq[0].due) begin
            mon_e = expq.pop_front();
            check("timeout", cyc, mon_e.due);
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] r1,
                         input logic [31:0] im, input logic [31:0] r2, input logic [3:0] tg,
                         input logic [31:0] xd, input logic [1:0] xf, input bit track);
        @(negedge clk);
        p_en = 1'b1; p_mem_w = w; p_bhw = f3; p_rs1 = r1; p_imm = im; p_rs2 = r2; p_tag = tg;
        if (track) expq.push_back('{tag: tg, data: xd, fault: xf, due: cyc + 4});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_finish", {31'h0, p_finish}, 32'd0);
        check("rst_data", p_data, 32'd0);
        check("rst_ready", {31'h0, p_ready}, 32'd1);
        check("rst_b_ready", {31'h0, b_ready}, 32'd1);
        rst_n = 1'b1;

        issue(1, F3_W,  32'h100, 32'h4,        32'hDEADBEEF, 4'd1,  32'h0,        2'b00, 1);
        issue(0, F3_W,  32'h100, 32'h4,        32'h0,        4'd2,  32'hDEADBEEF, 2'b00, 1);
        issue(0, F3_B,  32'h107, 32'h0,        32'h0,        4'd3,  32'hFFFFFFDE, 2'b00, 1);
        issue(0, F3_BU, 32'h107, 32'h0,        32'h0,        4'd4,  32'h000000DE, 2'b00, 1);
        issue(0, F3_H,  32'h104, 32'h0,        32'h0,        4'd5,  32'hFFFFBEEF, 2'b00, 1);
        issue(0, F3_HU, 32'h106, 32'h0,        32'h0,        4'd6,  32'h0000DEAD, 2'b00, 1);
        issue(1, F3_B,  32'h105, 32'h0,        32'hAAAAAA11, 4'd7,  32'h0,        2'b00, 1);
        issue(0, F3_W,  32'h104, 32'h0,        32'h0,        4'd8,  32'hDEAD11EF, 2'b00, 1);
        issue(1, F3_H,  32'h106, 32'h0,        32'h55552233, 4'd9,  32'h0,        2'b00, 1);
        issue(0, F3_W,  32'h108, 32'hFFFFFFFC, 32'h0,        4'd10, 32'h223311EF, 2'b00, 1);
        issue(0, F3_W,  32'h102, 32'h0,        32'h0,        4'd11, 32'h0,        2'b01, 1);
        issue(1, F3_W,  32'h100, 32'h0,        32'h01234567, 4'd12, 32'h0,        2'b00, 1);
        issue(1, F3_H,  32'h101, 32'h0,        32'h0000FFFF, 4'd13, 32'h0,        2'b01, 1);
        issue(0, F3_W,  32'h100, 32'h0,        32'h0,        4'd14, 32'h01234567, 2'b00, 1);
        issue(0, 3'b011, 32'h104, 32'h0,       32'h0,        4'd15, 32'h0,        2'b10, 1);
        issue(1, F3_BU, 32'h104, 32'h0,        32'h00000099, 4'd0,  32'h0,        2'b10, 1);
        issue(0, F3_W,  32'h104, 32'h0,        32'h0,        4'd1,  32'h223311EF, 2'b00, 1);
        issue(0, F3_H,  32'h106, 32'h0,        32'h0,        4'd2,  32'h00002233, 2'b00, 1);
        @(negedge clk);
        p_en = 1'b0;
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
        check("drain", expq.size(), 32'd0);

        // Two loads in flight when reset hits must never finish.
        issue(0, F3_W, 32'h104, 32'h0, 32'h0, 4'd6, 32'h0, 2'b00, 0);
        issue(0, F3_W, 32'h100, 32'h0, 32'h0, 4'd7, 32'h0, 2'b00, 0);
        @(negedge clk);
        p_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_data", p_data, 32'd0);
        check("midrst_tag", {28'h0, p_tag_out}, 32'd0);
        check("midrst_fault", {30'h0, p_fault}, 32'd0);
        check("midrst_ready", {31'h0, p_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_finish", {31'h0, p_finish}, 32'd0);
        check("postrst_data", p_data, 32'd0);
        check("postrst_ready", {31'h0, p_ready}, 32'd1);

        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            check($sformatf("b_ready_k%0d", k), {31'h0, b_ready}, {31'h0, (k % 4 == 0) || (k == 13)});
            check($sformatf("b_finish_k%0d", k), {31'h0, b_finish}, {31'h0, (k % 4 == 1) && (k >= 5)});
            if (b_finish) $display("txn blk tag=%0d data=%h fault=%0d k=%0d", b_tag_out, b_data, b_fault, k);
            if (k == 5) begin
                check("b_tag0", {28'h0, b_tag_out}, 32'd3);
                check("b_data0", b_data, 32'h0);
            end
            if (k == 9) begin
                check("b_tag1", {28'h0, b_tag_out}, 32'd4);
                check("b_alias_lw", b_data, 32'hCAFEF00D);
            end
            if (k == 13) begin
                check("b_tag2", {28'h0, b_tag_out}, 32'd5);
                check("b_lb", b_data, 32'hFFFFFFCA);
                check("b_fault2", {30'h0, b_fault}, 32'd0);
            end
            case (k)
                0: begin b_en = 1; b_mem_w = 1; b_bhw = F3_W; b_rs1 = 32'h1000; b_imm = 32'h4; b_rs2 = 32'hCAFEF00D; b_tag = 4'd3; end
                4: begin b_mem_w = 0; b_bhw = F3_W; b_rs1 = 32'h0; b_imm = 32'h4; b_tag = 4'd4; end
                8: begin b_mem_w = 0; b_bhw = F3_B; b_rs1 = 32'h2000; b_imm = 32'h7; b_tag = 4'd5; end
                9: b_en = 0;
                default: ;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
